// File: rtl/cls_fault_mgr_if.sv
// ============================================================================
// Module     : cls_fault_mgr_if
// Description: Fault/clear inputs and status outputs of the lockstep fault
//              manager, bundled with master (stimulus) and slave (DUT) views.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cls_fault_mgr_if;
    logic        fault;
    logic        sw_clr;
    logic        core_halt;
    logic        core_rst;
    logic [1:0]  state;
    logic [7:0]  fault_cnt;
    logic        fatal;
    logic        irq;
    logic [31:0] first_fault_ts;
    logic        ts_valid;

    modport master (
        output fault, sw_clr,
        input  core_halt, core_rst, state, fault_cnt, fatal, irq,
               first_fault_ts, ts_valid
    );

    modport slave (
        input  fault, sw_clr,
        output core_halt, core_rst, state, fault_cnt, fatal, irq,
               first_fault_ts, ts_valid
    );
endinterface

`default_nettype wire

// File: rtl/cls_fault_mgr.sv
// ============================================================================
// Module     : cls_fault_mgr
// Description: Triple-core lockstep fault manager: retry via core reset and
//              settle window, lockout after MAX_RETRY, optional first-fault
//              timestamp enabled by macro CLS_FAULT_LOG_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module cls_fault_mgr #(
    parameter int RST_CYCLES   = 16,
    parameter int CLEAN_CYCLES = 8,
    parameter int MAX_RETRY    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cls_fault_mgr_if.slave     s_if
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_RESET  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [7:0] c_rst_last   = 8'(RST_CYCLES - 1);
    localparam logic [7:0] c_clean_last = 8'(CLEAN_CYCLES - 1);
    localparam logic [3:0] c_max_retry  = 4'(MAX_RETRY);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_retry_cnt;
    logic [3:0]  w_retry_base;
    logic [3:0]  w_next_retry;
    logic [7:0]  r_rst_cnt;
    logic [7:0]  r_clean_cnt;
    logic [7:0]  r_fault_cnt;
    logic        r_irq;
    logic        r_core_halt;
    logic        r_core_rst;
    logic        r_fatal;
    logic        w_accept;

    assign w_accept     = s_if.fault && ((r_state == ST_RUN) || (r_state == ST_SETTLE));
    // A clear coincident with a fault takes effect before the retry decision.
    assign w_retry_base = s_if.sw_clr ? 4'd0 : r_retry_cnt;

    always_comb begin
        w_next_state = r_state;
        w_next_retry = w_retry_base;
        if (w_accept) begin
            if (w_retry_base < c_max_retry) begin
                w_next_retry = w_retry_base + 4'd1;
                w_next_state = ST_RESET;
            end else begin
                w_next_state = ST_LOCKED;
            end
        end else begin
            case (r_state)
                ST_RESET:  if (r_rst_cnt == c_rst_last)     w_next_state = ST_SETTLE;
                ST_SETTLE: if (r_clean_cnt == c_clean_last) w_next_state = ST_RUN;
                ST_LOCKED: if (s_if.sw_clr)                 w_next_state = ST_RUN;
                default:   w_next_state = r_state;
            endcase
        end
    end

    // Outputs are registered from the next state so they change together with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_retry_cnt <= 4'd0;
            r_rst_cnt   <= 8'd0;
            r_clean_cnt <= 8'd0;
            r_fault_cnt <= 8'd0;
            r_irq       <= 1'b0;
            r_core_halt <= 1'b0;
            r_core_rst  <= 1'b0;
            r_fatal     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_retry_cnt <= w_next_retry;
            r_rst_cnt   <= ((r_state == ST_RESET) && (w_next_state == ST_RESET))
                           ? r_rst_cnt + 8'd1 : 8'd0;
            r_clean_cnt <= ((r_state == ST_SETTLE) && (w_next_state == ST_SETTLE))
                           ? r_clean_cnt + 8'd1 : 8'd0;
            if (w_accept && (r_fault_cnt != 8'hFF)) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
            r_irq       <= w_accept;
            r_core_halt <= (w_next_state == ST_RESET) || (w_next_state == ST_LOCKED);
            r_core_rst  <= (w_next_state == ST_RESET);
            r_fatal     <= (w_next_state == ST_LOCKED);
        end
    end

    assign s_if.state     = r_state;
    assign s_if.core_halt = r_core_halt;
    assign s_if.core_rst  = r_core_rst;
    assign s_if.fatal     = r_fatal;
    assign s_if.irq       = r_irq;
    assign s_if.fault_cnt = r_fault_cnt;

`ifdef CLS_FAULT_LOG_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_first_ts;
    logic        r_ts_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
            r_first_ts  <= 32'd0;
            r_ts_valid  <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_accept && !r_ts_valid) begin
                r_first_ts <= r_cycle_cnt;
                r_ts_valid <= 1'b1;
            end
        end
    end

    assign s_if.first_fault_ts = r_first_ts;
    assign s_if.ts_valid       = r_ts_valid;
`else
    assign s_if.first_fault_ts = 32'd0;
    assign s_if.ts_valid       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cls_fault_mgr.sv
// ============================================================================
// Module     : tb_cls_fault_mgr
// Description: Directed and random bench for cls_fault_mgr against a
//              mode/countdown reference model (honours CLS_FAULT_LOG_EN).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cls_fault_mgr;

    localparam int RST_CYCLES   = 16;
    localparam int CLEAN_CYCLES = 8;
    localparam int MAX_RETRY    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cls_fault_mgr_if u_if ();

    cls_fault_mgr #(
        .RST_CYCLES   (RST_CYCLES),
        .CLEAN_CYCLES (CLEAN_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 RUN, 1 RESET, 2 SETTLE, 3 LOCKED; m_left = cycles remaining in mode.
    int          m_mode;
    int          m_left;
    int          m_retry;
    int          m_cnt;
    bit          m_irq;
    bit [31:0]   m_cyc;
    bit [31:0]   m_ts;
    bit          m_tsv;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_retry = 0; m_cnt = 0; m_irq = 1'b0;
        m_cyc = 32'd0; m_ts = 32'd0; m_tsv = 1'b0;
    endtask

    task automatic model_edge(bit f, bit c);
        bit acc;
        acc   = f && (m_mode == 0 || m_mode == 2);
        m_irq = acc;
        if (c) m_retry = 0;
        if (acc) begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
`ifdef CLS_FAULT_LOG_EN
            if (!m_tsv) begin m_ts = m_cyc; m_tsv = 1'b1; end
`endif
            if (m_retry < MAX_RETRY) begin
                m_retry = m_retry + 1;
                m_mode  = 1;
                m_left  = RST_CYCLES;
            end else begin
                m_mode = 3;
            end
        end else begin
            case (m_mode)
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_mode = 2; m_left = CLEAN_CYCLES; end
                end
                2: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = 0;
                end
                3: if (c) m_mode = 0;
                default: ;
            endcase
        end
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",     32'(u_if.state),          32'(m_mode));
        chk("core_halt", 32'(u_if.core_halt),      32'(m_mode == 1 || m_mode == 3));
        chk("core_rst",  32'(u_if.core_rst),       32'(m_mode == 1));
        chk("fatal",     32'(u_if.fatal),          32'(m_mode == 3));
        chk("irq",       32'(u_if.irq),            32'(m_irq));
        chk("fault_cnt", 32'(u_if.fault_cnt),      32'(m_cnt));
        chk("first_ts",  u_if.first_fault_ts,      m_ts);
        chk("ts_valid",  32'(u_if.ts_valid),       32'(m_tsv));
    endtask

    task automatic step(bit f, bit c);
        u_if.fault  = f;
        u_if.sw_clr = c;
        @(posedge clk);
        model_edge(f, c);
        #1;
        check_all();
    endtask

    task automatic run_until(int mode, int budget);
        int n;
        n = 0;
        while (m_mode != mode && n < budget) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("reach_state", 32'(u_if.state), 32'(mode));
    endtask

    int exp_ts;

    initial begin
        u_if.fault  = 1'b0;
        u_if.sw_clr = 1'b0;
        model_reset();

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_all();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();

        // Single fault: irq one cycle, RESET 16, SETTLE 8, RUN
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("single_irq", 32'(u_if.irq), 32'd1);
        repeat (RST_CYCLES - 1) step(1'b0, 1'b0);
        chk("single_still_reset", 32'(u_if.core_rst), 32'd1);
        step(1'b0, 1'b0);
        chk("single_settle", 32'(u_if.state), 32'd2);
        repeat (CLEAN_CYCLES) step(1'b0, 1'b0);
        chk("single_run", 32'(u_if.state), 32'd0);
        chk("single_cnt", 32'(u_if.fault_cnt), 32'd1);

        // Lockout: clear retries, then four faults each from RUN
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            if (i < 3) run_until(0, 100);
        end
        chk("lock_state", 32'(u_if.state), 32'd3);
        chk("lock_fatal", 32'(u_if.fatal), 32'd1);
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("lock_release", 32'(u_if.fatal), 32'd0);

        // Settle fault at SETTLE cycle 5
        step(1'b1, 1'b0);
        run_until(2, 40);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("settle_fault_reset", 32'(u_if.state), 32'd1);
        run_until(0, 60);

        // Fault held high through RESET: only the SETTLE sample is accepted
        step(1'b1, 1'b0);
        repeat (RST_CYCLES) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        run_until(0, 60);

        // Clear coincident with fault
        step(1'b1, 1'b1);
        chk("coincident_reset", 32'(u_if.state), 32'd1);
        run_until(0, 60);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
        end

        // Saturation of the fault counter
        for (int i = 0; i < 5000; i++) step(1'b1, 1'b1);
        chk("sat_cnt", 32'(u_if.fault_cnt), 32'd255);
        step(1'b0, 1'b1);
        run_until(0, 60);

        // Reset asserted at RESET cycle 7, checked without a clock edge
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        chk("midrst_cnt", 32'(u_if.fault_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();

        // Timestamp of first fault sampled at cycle 100, kept over a second fault
        repeat (100) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
`ifdef CLS_FAULT_LOG_EN
        exp_ts = 100;
`else
        exp_ts = 0;
`endif
        chk("ts_first", u_if.first_fault_ts, 32'(exp_ts));
        run_until(0, 60);
        step(1'b1, 1'b0);
        chk("ts_kept", u_if.first_fault_ts, 32'(exp_ts));
        run_until(0, 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cls_fault_mgr.md
CLS_FAULT_MGR -- requirements
Module: cls_fault_mgr

Interface
REQ-001 SHALL have parameter RST_CYCLES, 16, core-reset hold length in cycles (legal 1..255).
REQ-002 SHALL have parameter CLEAN_CYCLES, 8, consecutive fault-free cycles required after reset release (legal 1..255).
REQ-003 SHALL have parameter MAX_RETRY, 3, recovery attempts allowed before lockout (legal 0..15).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port fault  input  1  registered lockstep-comparator fault flag.
REQ-007 SHALL have port sw_clr  input  1  single-cycle software clear/acknowledge.
REQ-008 SHALL have port core_halt  output  1  stall request to all three cores.
REQ-009 SHALL have port core_rst  output  1  synchronous reset request to all three cores.
REQ-010 SHALL have port state  output  2  FSM state: 0 RUN, 1 RESET, 2 SETTLE, 3 LOCKED.
REQ-011 SHALL have port fault_cnt  output  8  total accepted faults since rst, saturating at 255.
REQ-012 SHALL have port fatal  output  1  retries exhausted, cores held.
REQ-013 SHALL have port irq  output  1  one-cycle pulse per accepted fault.
REQ-014 SHALL have port first_fault_ts  output  32  cycle stamp of first accepted fault.
REQ-015 SHALL have port ts_valid  output  1  first_fault_ts holds a captured value.

Function
REQ-016 SHALL implement a registered Moore FSM; core_halt=1 in RESET and LOCKED, core_rst=1 only in RESET, fatal=1 only in LOCKED.
REQ-017 SHALL "accept" a fault when fault=1 is sampled in RUN or SETTLE; fault is ignored in RESET and LOCKED.
REQ-018 SHALL, on accepted fault, increment fault_cnt (saturating), pulse irq in the next cycle, and compare internal 4-bit retry_cnt with MAX_RETRY.
REQ-019 SHALL, if retry_cnt < MAX_RETRY, increment retry_cnt and enter RESET; otherwise enter LOCKED without incrementing.
REQ-020 SHALL give one-cycle latency: fault sampled at edge N -> state/core_rst/core_halt/irq changed after edge N.
REQ-021 SHALL hold RESET for exactly RST_CYCLES cycles, then enter SETTLE.
REQ-022 SHALL, in SETTLE, count consecutive fault=0 cycles; reaching CLEAN_CYCLES enters RUN; an accepted fault restarts the count and follows REQ-019.
REQ-023 SHALL, on sw_clr in LOCKED, enter RUN and clear retry_cnt; in other states sw_clr clears retry_cnt only.
REQ-024 SHALL, on sw_clr coincident with accepted fault, apply clear first, so retry_cnt becomes 1 and state goes to RESET (MAX_RETRY>0) or LOCKED (MAX_RETRY=0).
REQ-025 SHALL never clear fault_cnt except by rst; sw_clr does not affect fault_cnt or timestamp.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-RESET, immediately force state=RUN, core_halt=0, core_rst=0, fatal=0, irq=0, fault_cnt=0, retry_cnt=0, all internal counters=0, first_fault_ts=0, ts_valid=0.
REQ-027 SHALL begin normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-028 SHALL, with CLS_FAULT_LOG_EN defined, run a free-running wrapping 32-bit cycle counter (0 at reset) and latch its value into first_fault_ts with ts_valid=1 on the first accepted fault after rst; later faults do not overwrite.
REQ-029 SHALL, without CLS_FAULT_LOG_EN, omit the counter and tie first_fault_ts=0, ts_valid=0.

Verification
REQ-030 SHALL cover single fault: defaults, fault=1 one cycle in RUN -> irq one cycle, core_rst=1 for 16 cycles, SETTLE 8 clean cycles, RUN; fault_cnt=1.
REQ-031 SHALL cover lockout: 4 faults each after returning to RUN -> 4th gives state=3, fatal=1, core_halt=1, fault_cnt=4; sw_clr -> RUN, fatal=0.
REQ-032 SHALL cover settle fault: fault=1 at SETTLE cycle 5 -> back to RESET, retry_cnt=2, clean counter restarts.
REQ-033 SHALL cover ignore window: fault held high throughout RESET -> no extra fault_cnt increment until SETTLE sampling.
REQ-034 SHALL cover reset mid-operation: rst asserted at RESET cycle 7 -> all outputs at reset values without a clock edge.
REQ-035 SHALL cover logging: with CLS_FAULT_LOG_EN, first fault sampled at cycle 100 after reset -> first_fault_ts=100, ts_valid=1, unchanged by second fault; without macro both 0.
